// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that runs one full-adder slice over WIDTH cycles, LSB first,
// and returns a registered sum, carry-out and signed-overflow flag.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic [CW-1:0] cnt;
   logic carry, fa_s, fa_c;
   full_adder fa (.x(a_sh[0]), .y(b_sh[0]), .ci(carry), .s(fa_s), .co(fa_c));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         c_out  <= 1'b0;
         ovf    <= 1'b0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
         carry  <= fa_c;
         cnt    <= cnt + CW'(1);
         if (cnt == CW'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB here, so ovf is taken before it updates
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {fa_s, sum_sh[WIDTH-1:1]};
            c_out <= fa_c;
            ovf   <= carry ^ fa_c;
         end
      end else begin
         done <= 1'b0;
         if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for 8-bit and 2-bit serial adders against an arithmetic model.
module tb_serial_add_ctrl;
   typedef struct packed {
      logic [9:0] r;
      int         t;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start8 = 1'b0, c_in8 = 1'b0, busy8, done8, c_out8, ovf8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic start2 = 1'b0, c_in2 = 1'b0, busy2, done2, c_out2, ovf2;
   logic [1:0] a2 = '0, b2 = '0, sum2;
   int checks = 0, errors = 0, cyc = 0, run8 = 0, run2 = 0;
   exp_t q8[$], q2[$];
   exp_t e8, e2;
   logic [9:0] last8 = '0, last2 = '0, got8, got2;

   serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c_in8),
      .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .ovf(ovf8));
   serial_add_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
      .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2), .ovf(ovf2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {c_out, ovf, sum} from plain unsigned and two's-complement arithmetic
   function automatic logic [9:0] model(input int w, input int a, input int b, input int c);
      int u, s, sa, sb, sv;
      logic o, co;
      u  = a + b + c;
      s  = u % (1 << w);
      co = (u >> w) != 0;
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      sv = sa + sb + c;
      o  = (sv > (1 << (w - 1)) - 1) || (sv < -(1 << (w - 1)));
      return {co, o, s[7:0]};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last8 = '0;
         run8 = 0;
      end else begin
         got8 = {c_out8, ovf8, sum8};
         if (done8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done8 got=%h required no done", got8);
            end else begin
               e8 = q8.pop_front();
               if (got8 !== e8.r || cyc != e8.t || run8 != 8 || busy8) begin
                  errors++;
                  $display("FAIL result8 got=%h cyc=%0d busy_len=%0d busy=%0b required=%h cyc=%0d busy_len=8 busy=0",
                     got8, cyc, run8, busy8, e8.r, e8.t);
               end
               last8 = e8.r;
            end
            run8 = 0;
         end else begin
            checks++;
            if (got8 !== last8) begin
               errors++;
               $display("FAIL hold8 got=%h required=%h", got8, last8);
            end
            run8 = busy8 ? run8 + 1 : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         last2 = '0;
         run2 = 0;
      end else begin
         got2 = {c_out2, ovf2, 6'b0, sum2};
         if (done2) begin
            checks++;
            if (q2.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done2 got=%h required no done", got2);
            end else begin
               e2 = q2.pop_front();
               if (got2 !== e2.r || cyc != e2.t || run2 != 2 || busy2) begin
                  errors++;
                  $display("FAIL result2 got=%h cyc=%0d busy_len=%0d busy=%0b required=%h cyc=%0d busy_len=2 busy=0",
                     got2, cyc, run2, busy2, e2.r, e2.t);
               end
               last2 = e2.r;
            end
            run2 = 0;
         end else begin
            checks++;
            if (got2 !== last2) begin
               errors++;
               $display("FAIL hold2 got=%h required=%h", got2, last2);
            end
            run2 = busy2 ? run2 + 1 : 0;
         end
      end
   end

   task automatic check_zero(input string name);
      checks++;
      if ({busy8, done8, sum8, c_out8, ovf8, busy2, done2, sum2, c_out2, ovf2} !== '0) begin
         errors++;
         $display("FAIL %s busy8=%0b done8=%0b sum8=%h c8=%0b ovf8=%0b busy2=%0b done2=%0b sum2=%h required all zero",
            name, busy8, done8, sum8, c_out8, ovf8, busy2, done2, sum2);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q8.size() != 0 || q2.size() != 0); i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (q8.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL timeout pending8=%0d pending2=%0d required 0", q8.size(), q2.size());
         q8.delete();
         q2.delete();
      end
   endtask

   task automatic issue8(input int a, input int b, input int c, input bit wait_done);
      @(negedge clk);
      a8 = 8'(a);
      b8 = 8'(b);
      c_in8 = c[0];
      start8 = 1'b1;
      q8.push_back('{model(8, a, b, c), cyc + 9});
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c_in8 = 1'($urandom);
      if (wait_done) drain();
   endtask

   task automatic issue2(input int a, input int b, input int c);
      @(negedge clk);
      a2 = 2'(a);
      b2 = 2'(b);
      c_in2 = c[0];
      start2 = 1'b1;
      q2.push_back('{model(2, a, b, c), cyc + 3});
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      drain();
   endtask

   task automatic pulse_reset(input string name);
      @(negedge clk);
      #2 rst = 1'b1;
      q8.delete();
      q2.delete();
      #1 check_zero(name);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      #3 check_zero("reset_initial");
      @(negedge clk);
      #2 rst = 1'b0;
      issue8(8'h0F, 8'h01, 0, 1);
      pulse_reset("reset_idle");
      issue8(8'hFF, 8'h01, 0, 1);
      issue8(8'h7F, 8'h01, 0, 1);
      issue8(8'h80, 8'h80, 1, 0);
      repeat (3) @(negedge clk);
      a8 = '0;
      b8 = '0;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      drain();
      issue8(8'h55, 8'hAA, 1, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      q8.delete();
      #1 check_zero("reset_run");
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (15) @(negedge clk);
      begin
         int c0;
         @(negedge clk);
         a8 = 8'h01;
         b8 = 8'h02;
         c_in8 = 1'b1;
         start8 = 1'b1;
         c0 = cyc;
         for (int k = 0; k < 4; k++) q8.push_back('{model(8, 1, 2, 1), c0 + 9 + 9 * k});
         repeat (30) @(negedge clk);
         start8 = 1'b0;
         drain();
      end
      for (int i = 0; i < 24; i++) issue8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1);
      for (int i = 0; i < 32; i++) issue2(i & 3, (i >> 2) & 3, i >> 4);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
